// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO pair (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MDU_DIVIDE_EN to build the divide datapath; otherwise DIV/DIVU complete quickly with HI=LO=0.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             kill,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wdat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand signs only matter for the signed ops; magnitudes feed the unsigned core.
  logic             rs_neg_c, rt_neg_c;
  logic [WIDTH-1:0] rs_mag_c, rt_mag_c;
  assign rs_neg_c = op[0] & rs_data[WIDTH-1];
  assign rt_neg_c = op[0] & rt_data[WIDTH-1];
  assign rs_mag_c = rs_neg_c ? (-rs_data) : rs_data;
  assign rt_mag_c = rt_neg_c ? (-rt_data) : rt_data;

  // Shift-add step: upper half accumulates, lower half shifts the multiplier out.
  logic [WIDTH:0]   mul_sum_c;
  logic [PW-1:0]    mul_next_c;
  logic [PW-1:0]    mul_res_c;
  assign mul_sum_c  = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign mul_next_c = {mul_sum_c, p_q[WIDTH-1:1]};
  assign mul_res_c  = (sa_q ^ sb_q) ? (-p_q) : p_q;

`ifdef MDU_DIVIDE_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   div_shift_c, div_diff_c;
  logic             div_ok_c;
  logic [PW-1:0]    div_next_c;
  // Restoring step: upper half is the partial remainder, lower half collects quotient bits.
  assign div_shift_c = {p_q[PW-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff_c  = div_shift_c - {1'b0, b_q};
  assign div_ok_c    = ~div_diff_c[WIDTH];
  assign div_next_c  = {(div_ok_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0]),
                        p_q[WIDTH-2:0], div_ok_c};
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      a_q    <= '0;
      p_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MDU_DIVIDE_EN
      b_q    <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      a_q    <= a_d;
      p_q    <= p_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef MDU_DIVIDE_EN
      b_q    <= b_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    a_d    = a_q;
    p_d    = p_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
`ifdef MDU_DIVIDE_EN
    b_d    = b_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!kill) begin
          if (hi_wen) hi_d = wdat;
          if (lo_wen) lo_d = wdat;
          if (start) begin
            div_d = op[1];
            sa_d  = rs_neg_c;
            sb_d  = rt_neg_c;
            a_d   = rs_mag_c;
            cnt_d = CW'(WIDTH - 1);
            p_d   = {{WIDTH{1'b0}}, (op[1] ? rs_mag_c : rt_mag_c)};
`ifdef MDU_DIVIDE_EN
            b_d   = rt_mag_c;
`else
            if (op[1]) cnt_d = '0;
`endif
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
`ifdef MDU_DIVIDE_EN
        p_d = div_q ? div_next_c : mul_next_c;
`else
        p_d = mul_next_c;
`endif
      end
      S_FIX: begin
        if (!kill) begin
          done_d = 1'b1;
          if (div_q) begin
`ifdef MDU_DIVIDE_EN
            // Divide by zero returns all-ones quotient and the original dividend.
            if (b_q == '0) begin
              lo_d = '1;
              hi_d = sa_q ? (-a_q) : a_q;
            end else begin
              lo_d = (sa_q ^ sb_q) ? (-p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
              hi_d = sa_q ? (-p_q[PW-1:WIDTH]) : p_q[PW-1:WIDTH];
            end
`else
            lo_d = '0;
            hi_d = '0;
`endif
          end else begin
            hi_d = mul_res_c[PW-1:WIDTH];
            lo_d = mul_res_c[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
